// File: rtl/four_phase_arbiter.sv
// Two-client round-robin mutex arbiter with four-phase handshakes toward the
// clients and toward the downstream muller_c stage, plus saturating grant counters.
module four_phase_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    output logic             ack0,
    output logic             ack1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             res_req,
    input  logic             res_ack,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [2:0] {IDLE, GRANT, ACK, RELEASE, DONE} state_t;

    state_t                 state;
    logic                   last;
    logic                   sel;
    logic [SYNC_STAGES-1:0] req0_sync;
    logic [SYNC_STAGES-1:0] req1_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   req0_s;
    logic                   req1_s;
    logic                   res_ack_s;
    logic                   req_sel_s;
    logic                   pick;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req0_s    = req0_sync[SYNC_STAGES-1];
    assign req1_s    = req1_sync[SYNC_STAGES-1];
    assign res_ack_s = ack_sync[SYNC_STAGES-1];
    assign req_sel_s = sel ? req1_s : req0_s;

    // On a tie the client that did not win last time is chosen.
    always_comb begin
        pick = req1_s;
        if (req0_s && req1_s) pick = ~last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req0_sync <= '0;
            req1_sync <= '0;
            ack_sync  <= '0;
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            res_req   <= 1'b0;
            busy      <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            req0_sync <= {req0_sync[SYNC_STAGES-2:0], req0};
            req1_sync <= {req1_sync[SYNC_STAGES-2:0], req1};
            ack_sync  <= {ack_sync[SYNC_STAGES-2:0], res_ack};
            case (state)
                IDLE: begin
                    if (req0_s || req1_s) begin
                        sel     <= pick;
                        last    <= pick;
                        gnt0    <= ~pick;
                        gnt1    <= pick;
                        res_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (res_ack_s) begin
                        ack0  <= ~sel;
                        ack1  <= sel;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!req_sel_s) begin
                        res_req <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!res_ack_s) begin
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not looked at here, guaranteeing an idle cycle between grants.
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (sel) cnt1 <= sat_inc(cnt1);
                    else     cnt0 <= sat_inc(cnt0);
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
